// File: rtl/lms_error_gen_if.sv
// Sample/coefficient/error bundle of the 2-tap LMS error generator.
// master = sample source + coefficient block, slave = lms_error_gen.
interface lms_error_gen_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] y_in;
  logic signed [COEF_W-1:0] a_hat_current;
  logic signed [COEF_W-1:0] b_hat_current;
  logic signed [DATA_W-1:0] e_current;
  logic signed [DATA_W-1:0] x_last;
  logic signed [DATA_W-1:0] y_last;
  logic                     flag_e_out;

  modport master (
    output in_valid, x_in, y_in,
    output a_hat_current, b_hat_current,
    input  in_ready, e_current,
    input  x_last, y_last, flag_e_out
  );

  modport slave (
    input  in_valid, x_in, y_in,
    input  a_hat_current, b_hat_current,
    output in_ready, e_current,
    output x_last, y_last, flag_e_out
  );
endinterface

// File: rtl/lms_error_gen.sv
// Forward/error path of the 2-tap LMS identifier, one shared multiplier.
// LMS_ERR_SAT_EN: saturate the error instead of two's-complement wrap.
module lms_error_gen #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int FRAC_W = 0
) (
  input logic clk,
  input logic rst,
  lms_error_gen_if.slave bus
);
  localparam int PW = DATA_W + COEF_W + 1;
  localparam int SW = DATA_W + COEF_W + 2;
  localparam int MAXI = 2 ** (DATA_W - 1) - 1;
  localparam int MINI = -(2 ** (DATA_W - 1));
  localparam logic signed [SW-1:0] SMAX = SW'(MAXI);
  localparam logic signed [SW-1:0] SMIN = SW'(MINI);

  typedef enum logic [2:0] {
    IDLE, MUL_A, MUL_B, SUM, OUT
  } state_t;

  state_t                   state_q;
  logic                     rdy_q;
  logic                     flag_q;
  logic signed [DATA_W-1:0] xn_q, yn_q;
  logic signed [DATA_W-1:0] xh_q, yh_q;
  logic signed [COEF_W-1:0] a_q, b_q;
  logic signed [PW-1:0]     acc_q;
  logic signed [DATA_W-1:0] e_q, xl_q, yl_q;

  logic signed [COEF_W-1:0] m_c_d;
  logic signed [DATA_W-1:0] m_x_d;
  logic signed [PW-1:0]     prod_d;
  logic signed [SW-1:0]     diff_d;
  logic signed [DATA_W-1:0] fit_d;

  // Shared multiplier operands, difference and output fit.
  // The difference feeds the output registers directly so that
  // the flag pulse and the new error appear in the same cycle.
  always_comb begin
    m_c_d = a_q;
    m_x_d = xh_q;
    if (state_q == MUL_B) begin
      m_c_d = b_q;
      m_x_d = yh_q;
    end
    prod_d = PW'(m_c_d) * PW'(m_x_d);
    diff_d = SW'(yn_q) - SW'(acc_q >>> FRAC_W);
`ifdef LMS_ERR_SAT_EN
    if (diff_d > SMAX)
      fit_d = DATA_W'(SMAX);
    else if (diff_d < SMIN)
      fit_d = DATA_W'(SMIN);
    else
      fit_d = DATA_W'(diff_d);
`else
    fit_d = DATA_W'(diff_d);
`endif
  end

  // Sequencer: accept, two multiply steps, subtract, publish.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      flag_q  <= 1'b0;
      xn_q    <= '0;
      yn_q    <= '0;
      xh_q    <= '0;
      yh_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      e_q     <= '0;
      xl_q    <= '0;
      yl_q    <= '0;
    end else begin
      flag_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (rdy_q && bus.in_valid) begin
            xn_q    <= bus.x_in;
            yn_q    <= bus.y_in;
            a_q     <= bus.a_hat_current;
            b_q     <= bus.b_hat_current;
            rdy_q   <= 1'b0;
            state_q <= MUL_A;
          end
        end
        MUL_A: begin
          acc_q   <= prod_d;
          state_q <= MUL_B;
        end
        MUL_B: begin
          acc_q   <= acc_q + prod_d;
          state_q <= SUM;
        end
        SUM: begin
          e_q     <= fit_d;
          xl_q    <= xh_q;
          yl_q    <= yh_q;
          xh_q    <= xn_q;
          yh_q    <= yn_q;
          flag_q  <= 1'b1;
          state_q <= OUT;
        end
        OUT: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          rdy_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = rdy_q;
  assign bus.flag_e_out = flag_q;
  assign bus.e_current  = e_q;
  assign bus.x_last     = xl_q;
  assign bus.y_last     = yl_q;
endmodule

// File: tb/tb_lms_error_gen.sv
// Directed bench for lms_error_gen: vector table plus
// back-to-back, mid-operation reset and coefficient-capture cases.
module tb_lms_error_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lms_error_gen_if #(.DATA_W(8), .COEF_W(8)) bus ();

  lms_error_gen #(
    .DATA_W(8),
    .COEF_W(8),
    .FRAC_W(0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int x;
    int y;
    int a;
    int b;
    int e_wrap;
    int e_sat;
    int xl;
    int yl;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One sample: coefficients are inverted right after accept, so the
  // result only matches if the accept-time values were captured.
  task automatic sample(input int x, input int y, input int a,
                        input int b, output int lat, output int e,
                        output int xl, output int yl);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      chk("ready_timeout", 0, 1);
    end
    bus.in_valid      = 1'b1;
    bus.x_in          = 8'(x);
    bus.y_in          = 8'(y);
    bus.a_hat_current = 8'(a);
    bus.b_hat_current = 8'(b);
    @(posedge clk);
    #1;
    bus.in_valid      = 1'b0;
    bus.a_hat_current = ~bus.a_hat_current;
    bus.b_hat_current = ~bus.b_hat_current;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2) chk("busy_ready", int'(bus.in_ready), 0);
    end while (!bus.flag_e_out && lat < 12);
    e  = int'(bus.e_current);
    xl = int'(bus.x_last);
    yl = int'(bus.y_last);
    @(negedge clk);
    chk("flag_width", int'(bus.flag_e_out), 0);
    chk("ready_again", int'(bus.in_ready), 1);
  endtask

  initial begin
    int lat, e, xl, yl, exp_e, nflag;
    int acc_c[$];
    int flg_c[$];

    tbl[0] = '{5, 3, 0, 0, 3, 3, 0, 0};
    tbl[1] = '{1, 20, 2, 1, 7, 7, 5, 3};
    tbl[2] = '{-4, -10, -3, 2, -47, -47, 1, 20};
    tbl[3] = '{127, 127, 0, 0, 127, 127, -4, -10};
    tbl[4] = '{0, -128, 127, 127, 126, -128, 127, 127};
    tbl[5] = '{-128, -128, -128, -1, 0, -128, 0, -128};
    tbl[6] = '{10, 10, 1, 1, 10, 127, -128, -128};

    bus.in_valid      = 1'b0;
    bus.x_in          = '0;
    bus.y_in          = '0;
    bus.a_hat_current = '0;
    bus.b_hat_current = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", int'(bus.in_ready), 0);
    chk("rst_flag", int'(bus.flag_e_out), 0);
    chk("rst_e", int'(bus.e_current), 0);
    chk("rst_xl", int'(bus.x_last), 0);
    chk("rst_yl", int'(bus.y_last), 0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      sample(tbl[i].x, tbl[i].y, tbl[i].a, tbl[i].b, lat, e, xl, yl);
`ifdef LMS_ERR_SAT_EN
      exp_e = tbl[i].e_sat;
`else
      exp_e = tbl[i].e_wrap;
`endif
      chk($sformatf("lat[%0d]", i), lat, 4);
      chk($sformatf("e[%0d]", i), e, exp_e);
      chk($sformatf("xl[%0d]", i), xl, tbl[i].xl);
      chk($sformatf("yl[%0d]", i), yl, tbl[i].yl);
    end

    // in_valid held high: accepts every 5 cycles, one flag each
    @(negedge clk);
    while (!bus.in_ready) @(negedge clk);
    bus.in_valid      = 1'b1;
    bus.x_in          = 8'sd3;
    bus.y_in          = 8'sd4;
    bus.a_hat_current = '0;
    bus.b_hat_current = '0;
    for (int c = 0; c < 15; c++) begin
      if (bus.in_ready) acc_c.push_back(c);
      if (bus.flag_e_out) flg_c.push_back(c);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("bb_accepts", acc_c.size(), 3);
    chk("bb_flags", flg_c.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("bb_acc_cyc", (k < acc_c.size()) ? acc_c[k] : -1, 5 * k);
      chk("bb_flag_cyc", (k < flg_c.size()) ? flg_c[k] : -1, 5 * k + 4);
    end

    // Reset asserted during MUL_B
    @(negedge clk);
    while (!bus.in_ready) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x_in     = 8'sd9;
    bus.y_in     = 8'sd9;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_e", int'(bus.e_current), 0);
    chk("mid_rst_xl", int'(bus.x_last), 0);
    chk("mid_rst_yl", int'(bus.y_last), 0);
    chk("mid_rst_ready", int'(bus.in_ready), 0);
    nflag = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.flag_e_out) nflag++;
    end
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.flag_e_out) nflag++;
    end
    chk("mid_rst_noflag", nflag, 0);
    sample(7, -9, 5, 5, lat, e, xl, yl);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_e", e, -9);
    chk("post_rst_xl", xl, 0);
    chk("post_rst_yl", yl, 0);

    // Coefficient change after accept must not leak in
    sample(2, 50, 3, 0, lat, e, xl, yl);
    chk("coef_cap_e", e, 50 - 3 * 7);
    chk("coef_cap_xl", xl, 7);
    chk("coef_cap_yl", yl, -9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
